// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divide sequencer and its serial core.
package div_seq_pkg;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = 32;
  localparam logic [DIV_W-1:0] DZ_LO_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    FIXUP,
    ZERO,
    DRAIN
  } state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Pipeline-side request/result bundle of the divide sequencer.
interface div_seq_ctrl_if;
  import div_seq_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [DIV_W-1:0] req_a;
  logic [DIV_W-1:0] req_b;
  logic             flush;
  logic             stall;
  logic             done;
  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] lo;
  logic             div_zero;

  modport master (
    output req_valid, req_signed, req_a, req_b, flush,
    input  req_ready, stall, done, hi, lo, div_zero
  );

  modport slave (
    input  req_valid, req_signed, req_a, req_b, flush,
    output req_ready, stall, done, hi, lo, div_zero
  );

endinterface

// File: rtl/div_seq_ctrl_core.sv
// Unsigned restoring serial divider: one quotient bit per cycle, no abort.
module div_seq_ctrl_core #(
  parameter int W    = 32,
  parameter int ITER = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CNT_W = $clog2(ITER + 1);

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     dvs;
  logic [W:0]       shifted;
  logic [W:0]       diff;
  logic [W-1:0]     rem_nxt;
  logic [W-1:0]     quo_nxt;

  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dvs};
    rem_nxt = shifted[W-1:0];
    quo_nxt = {quo[W-2:0], 1'b0};
    if (!diff[W]) begin
      rem_nxt = diff[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end
  end

  // Iteration counter runs down to terminal count zero, which is also idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (start && cnt == '0) begin
      cnt <= CNT_W'(ITER);
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  assign busy      = (cnt != '0);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/div_seq_ctrl.sv
// EX-stage DIV/DIVU sequencer: sign handling, core start, divide-by-zero bypass, flush.
//  state | meaning
//  IDLE  | ready for a request
//  START | core_start pulse
//  RUN   | core iterating
//  FIXUP | sign-correct and write HI/LO
//  ZERO  | divide-by-zero bypass write
//  DRAIN | flushed, waiting for the core to go idle
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int               WIDTH = DIV_W,
  parameter logic [DIV_W-1:0] DZ_LO = DZ_LO_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  div_seq_ctrl_if.slave bus
);

  state_t state_q;
  state_t state_d;

  logic             core_start;
  logic             core_busy;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;

  logic             accept;
  logic             wr_res;
  logic             wr_zero;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? ('0 - v) : v;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.flush && bus.req_valid) state_d = (bus.req_b == '0) ? ZERO : START;
      START:   state_d = bus.flush ? DRAIN : RUN;
      RUN:     if (bus.flush) state_d = DRAIN;
               else if (!core_busy) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      ZERO:    state_d = IDLE;
      DRAIN:   if (!core_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flush wins over an accept in IDLE and suppresses the result writes.
  always_comb begin
    core_start    = (state_q == START);
    bus.req_ready = (state_q == IDLE);
    bus.stall     = (state_q != IDLE);
    accept        = (state_q == IDLE) && bus.req_valid && !bus.flush;
    wr_res        = (state_q == FIXUP) && !bus.flush;
    wr_zero       = (state_q == ZERO) && !bus.flush;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      a_lat  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= wr_res || wr_zero;
      if (accept) begin
        sign_q <= bus.req_signed & (bus.req_a[WIDTH-1] ^ bus.req_b[WIDTH-1]);
        sign_r <= bus.req_signed & bus.req_a[WIDTH-1];
        mag_a  <= neg_if(bus.req_signed & bus.req_a[WIDTH-1], bus.req_a);
        mag_b  <= neg_if(bus.req_signed & bus.req_b[WIDTH-1], bus.req_b);
        a_lat  <= bus.req_a;
        dz_q   <= 1'b0;
      end
      if (wr_res) begin
        lo_q <= neg_if(sign_q, core_q);
        hi_q <= neg_if(sign_r, core_r);
      end
      if (wr_zero) begin
        hi_q <= a_lat;
        lo_q <= DZ_LO;
        dz_q <= 1'b1;
      end
    end
  end

  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

  div_seq_ctrl_core #(
    .W    (WIDTH),
    .ITER (DIV_ITER)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .start     (core_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (core_busy),
    .quotient  (core_q),
    .remainder (core_r)
  );

endmodule
